// File: rtl/sw_pkg.sv
// ============================================================================
// sw_pkg : shared encodings and ring helper for the stopwatch mode sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package sw_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_CLEAR = 2'd0,
      ST_START = 2'd1,
      ST_STOP  = 2'd2,
      ST_LOAD  = 2'd3
   } state_t;

   // Next slot of a ring of the given depth.
   function automatic int unsigned ring_step(input int unsigned idx, input int unsigned depth);
      return (idx + 1 >= depth) ? 0 : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_press_detector.sv
// ============================================================================
// btn_press_detector : rising-edge press pulse and one-shot long-hold pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_press_detector #(
   parameter int unsigned HOLD_CYC = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic press,
   output logic long_press
);

   localparam int CW = $clog2(HOLD_CYC + 1);

   logic          prev;
   logic [CW-1:0] hold_cnt;

   // Reset loads "already high" and a saturated counter, so a button held
   // through reset yields neither a press nor a long event until released.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= 1'b1;
         hold_cnt <= CW'(HOLD_CYC);
      end else begin
         prev <= level;
         if (!level) begin
            hold_cnt <= '0;
         end else if (hold_cnt != CW'(HOLD_CYC)) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   assign press      = level & ~prev;
   assign long_press = level & (hold_cnt == CW'(HOLD_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/stopwatch_mode_ctrl.sv
// ============================================================================
// stopwatch_mode_ctrl : CLEAR/START/STOP/LOAD sequencer with lap-time ring
// Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_mode_ctrl
   import sw_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 125_000_000,
   parameter int unsigned HOLD_SEC  = 3,
   parameter int unsigned LAP_DEPTH = 5
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 BTN0,
   input  logic                                 BTN1,
   output logic [STATE_W-1:0]                   STATE,
   output logic                                 CNT_EN,
   output logic                                 CNT_CLR,
   output logic                                 LAP_WE,
   output logic [$clog2(LAP_DEPTH)-1:0]         LAP_WADDR,
   output logic [$clog2(LAP_DEPTH)-1:0]         LAP_RADDR,
   output logic                                 LAP_SHOW,
   output logic [$clog2(LAP_DEPTH):0]           LAP_CNT
);

   localparam int unsigned HOLD_CYC = CLK_FREQ * HOLD_SEC;
   localparam int          IDX_W    = $clog2(LAP_DEPTH);
   localparam int          CNT_W    = IDX_W + 1;

   logic b0_press, b0_long, b1_press, b1_long;

   btn_press_detector #(.HOLD_CYC(HOLD_CYC)) u_btn0 (
      .clk        (CLK),
      .rst        (RST),
      .level      (BTN0),
      .press      (b0_press),
      .long_press (b0_long)
   );

   btn_press_detector #(.HOLD_CYC(HOLD_CYC)) u_btn1 (
      .clk        (CLK),
      .rst        (RST),
      .level      (BTN1),
      .press      (b1_press),
      .long_press (b1_long)
   );

   state_t             state;
   logic               cnt_clr;
   logic               lap_we;
   logic [IDX_W-1:0]   waddr;
   logic [IDX_W-1:0]   raddr;
   logic               lap_show;
   logic [CNT_W-1:0]   lap_cnt;
   logic               first_sel;

   logic [IDX_W-1:0]   oldest;
   logic [IDX_W-1:0]   newest;
   logic [IDX_W-1:0]   raddr_step;
   logic [IDX_W-1:0]   waddr_step;
   logic               clear_req;

   always_comb begin
      oldest     = (lap_cnt < CNT_W'(LAP_DEPTH)) ? '0 : waddr;
      newest     = (waddr == '0) ? IDX_W'(LAP_DEPTH - 1) : waddr - 1'b1;
      raddr_step = (first_sel || raddr == newest) ? oldest
                                                  : IDX_W'(ring_step(32'(raddr), LAP_DEPTH));
      waddr_step = IDX_W'(ring_step(32'(waddr), LAP_DEPTH));
      // BTN0 events take precedence over a simultaneous BTN1 long hold.
      clear_req  = b1_long && !b0_press &&
                   ((state == ST_STOP && !b0_long) || state == ST_LOAD);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_CLEAR;
         cnt_clr   <= 1'b1;
         lap_we    <= 1'b0;
         waddr     <= '0;
         raddr     <= '0;
         lap_show  <= 1'b0;
         lap_cnt   <= '0;
         first_sel <= 1'b1;
      end else begin
         cnt_clr <= 1'b0;
         lap_we  <= 1'b0;

         // The write pointer advances after the pulse so the RAM write
         // lands on the slot shown alongside LAP_WE.
         if (lap_we) begin
            waddr <= waddr_step;
            if (lap_cnt != CNT_W'(LAP_DEPTH)) begin
               lap_cnt <= lap_cnt + 1'b1;
            end
         end

         case (state)
            ST_CLEAR: begin
               if (b0_press) state <= ST_START;
            end
            ST_START: begin
               if (b0_press) begin
                  state <= ST_STOP;
               end else if (b1_press) begin
                  lap_we <= 1'b1;
               end
            end
            ST_STOP: begin
               if (b0_press) begin
                  state <= ST_START;
               end else if (b0_long) begin
                  state     <= ST_LOAD;
                  lap_show  <= 1'b0;
                  first_sel <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (b0_press) begin
                  state    <= ST_STOP;
                  lap_show <= 1'b0;
               end else if (b1_press && lap_cnt != '0) begin
                  raddr     <= raddr_step;
                  lap_show  <= 1'b1;
                  first_sel <= 1'b0;
               end
            end
            default: state <= ST_CLEAR;
         endcase

         if (clear_req) begin
            state    <= ST_CLEAR;
            cnt_clr  <= 1'b1;
            waddr    <= '0;
            raddr    <= '0;
            lap_cnt  <= '0;
            lap_show <= 1'b0;
         end
      end
   end

   assign STATE     = state;
   assign CNT_EN    = (state == ST_START);
   assign CNT_CLR   = cnt_clr;
   assign LAP_WE    = lap_we;
   assign LAP_WADDR = waddr;
   assign LAP_RADDR = raddr;
   assign LAP_SHOW  = lap_show;
   assign LAP_CNT   = lap_cnt;

endmodule

`default_nettype wire
